// File: rtl/single_port_ram_multimode.sv
// ============================================================================
// Module      : single_port_ram_multimode
// Description : Single-port synchronous RAM with byte enables, selectable
//               read-during-write mode, optional output register and
//               post-reset clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module single_port_ram_multimode #(
  parameter int MEM_WIDTH      = 24,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int RW_MODE        = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              we,
  input  logic [MEM_WIDTH/BYTE_WIDTH-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [MEM_WIDTH-1:0]              din,
  output logic [MEM_WIDTH-1:0]              dout,
  output logic                              dout_valid,
  output logic                              busy
);

  localparam int                    C_NUM_BYTES = MEM_WIDTH / BYTE_WIDTH;
  localparam int                    C_MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = {ADDR_WIDTH{1'b1}};

  if (RW_MODE > 2) begin : g_bad_rw_mode
    $error("single_port_ram_multimode: RW_MODE must be 0, 1 or 2");
  end
  if ((MEM_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
    $error("single_port_ram_multimode: MEM_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic [MEM_WIDTH-1:0]    r_mem [C_MEM_DEPTH];
  logic [MEM_WIDTH-1:0]    r_s1_data;
  logic                    r_s1_valid;

  logic [MEM_WIDTH-1:0]    w_old;
  logic [MEM_WIDTH-1:0]    w_merged;
  logic                    w_clearing;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [MEM_WIDTH-1:0]    w_mem_wdata;

  assign w_old = r_mem[addr];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < C_NUM_BYTES; i++) begin
      if (be[i]) begin
        w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Reset itself never touches the array; only the sequencer or an access does.
  assign w_clearing  = rst_n && (r_state == ST_CLEAR);
  assign w_mem_we    = w_clearing || (rst_n && (r_state == ST_READY) && en && we);
  assign w_mem_addr  = w_clearing ? r_clr_addr : addr;
  assign w_mem_wdata = w_clearing ? '0 : w_merged;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_addr <= '0;
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == C_LAST_ADDR) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (en) begin
            if (!we) begin
              r_s1_data  <= w_old;
              r_s1_valid <= 1'b1;
            end else if (RW_MODE == 0) begin
              r_s1_data  <= w_merged;
              r_s1_valid <= 1'b1;
            end else if (RW_MODE == 1) begin
              r_s1_data  <= w_old;
              r_s1_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [MEM_WIDTH-1:0] r_s2_data;
    logic                 r_s2_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_data  <= r_s1_data;
        r_s2_valid <= r_s1_valid;
      end
    end

    assign dout       = r_s2_data;
    assign dout_valid = r_s2_valid;
  end else begin : g_no_out_reg
    assign dout       = r_s1_data;
    assign dout_valid = r_s1_valid;
  end

  assign busy = (r_state == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_single_port_ram_multimode.sv
// ============================================================================
// Module      : tb_single_port_ram_multimode
// Description : Directed self-checking bench; four RAM variants share one
//               stimulus stream (write-first, read-first, no-change, out-reg).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_single_port_ram_multimode;

  logic        clk = 1'b0;
  logic        rst_n, en, we;
  logic [2:0]  be;
  logic [3:0]  addr;
  logic [23:0] din;

  logic [23:0] dout_wf, dout_rf, dout_nc, dout_or;
  logic        valid_wf, valid_rf, valid_nc, valid_or;
  logic        busy_wf, busy_rf, busy_nc, busy_or;

  int n_cmp = 0;
  int n_err = 0;
  int n_busy;
  int n_bad_valid;

  always #5 clk = ~clk;

  single_port_ram_multimode #(.MEM_WIDTH(24), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout_wf), .dout_valid(valid_wf), .busy(busy_wf));

  single_port_ram_multimode #(.MEM_WIDTH(24), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rf (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout_rf), .dout_valid(valid_rf), .busy(busy_rf));

  single_port_ram_multimode #(.MEM_WIDTH(24), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_nc (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout_nc), .dout_valid(valid_nc), .busy(busy_nc));

  single_port_ram_multimode #(.MEM_WIDTH(24), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_or (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout_or), .dout_valid(valid_or), .busy(busy_or));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic e, input logic w, input logic [2:0] b,
                     input logic [3:0] a, input logic [23:0] d);
    en = e; we = w; be = b; addr = a; din = d;
    tick();
  endtask

  // Edges until busy drops (0 if it never does within the bound).
  task automatic wait_idle(output int n);
    n = 0;
    n_bad_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid_wf || valid_rf || valid_or) n_bad_valid++;
      if (!busy_wf) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; we = 1'b0; be = 3'b000; addr = 4'd0; din = 24'd0;
    tick(); tick();
    chk("rst_busy",  32'(busy_wf),  32'd1);
    chk("rst_dout",  32'(dout_wf),  32'd0);
    chk("rst_valid", 32'(valid_or), 32'd0);

    // Clear sequence after release
    rst_n = 1'b1;
    wait_idle(n_busy);
    chk("clear_cycles", 32'(n_busy), 32'd16);
    chk("clear_no_valid", 32'(n_bad_valid), 32'd0);
    chk("clear_busy_or", 32'(busy_or), 32'd0);

    for (int a = 0; a < 16; a++) begin
      acc(1'b1, 1'b0, 3'b111, 4'(a), 24'h0);
      chk($sformatf("clr_rd%0d", a), 32'(dout_wf), 32'h0);
      chk($sformatf("clr_vld%0d", a), 32'(valid_wf), 32'd1);
    end

    // Byte-enable writes under each read-during-write mode
    acc(1'b1, 1'b1, 3'b111, 4'd3, 24'h112233);
    chk("wf_full_wr",   32'(dout_wf),  32'h112233);
    chk("rf_full_wr",   32'(dout_rf),  32'h000000);
    chk("nc_full_vld",  32'(valid_nc), 32'd0);
    acc(1'b1, 1'b1, 3'b010, 4'd3, 24'hAABBCC);
    chk("wf_part_wr",   32'(dout_wf),  32'h11BB33);
    chk("wf_part_vld",  32'(valid_wf), 32'd1);
    chk("rf_part_wr",   32'(dout_rf),  32'h112233);
    chk("nc_part_dout", 32'(dout_nc),  32'h000000);
    acc(1'b1, 1'b0, 3'b000, 4'd3, 24'h0);
    chk("wf_rd3", 32'(dout_wf), 32'h11BB33);
    chk("rf_rd3", 32'(dout_rf), 32'h11BB33);
    chk("nc_rd3", 32'(dout_nc), 32'h11BB33);
    acc(1'b0, 1'b0, 3'b000, 4'd0, 24'h0);
    chk("idle_vld",  32'(valid_wf), 32'd0);
    chk("idle_hold", 32'(dout_wf),  32'h11BB33);
    chk("or_lag",    32'(dout_or),  32'h11BB33);
    chk("or_lag_vld", 32'(valid_or), 32'd1);

    // No-change mode
    acc(1'b1, 1'b1, 3'b111, 4'd0, 24'h0000AA);
    chk("nc_wr_hold", 32'(dout_nc), 32'h11BB33);
    acc(1'b1, 1'b0, 3'b000, 4'd0, 24'h0);
    chk("nc_rd0",     32'(dout_nc),  32'h0000AA);
    chk("nc_rd0_vld", 32'(valid_nc), 32'd1);
    acc(1'b1, 1'b1, 3'b111, 4'd0, 24'hFFFFFF);
    chk("nc_wr2_dout", 32'(dout_nc),  32'h0000AA);
    chk("nc_wr2_vld",  32'(valid_nc), 32'd0);
    chk("rf_wr2_old",  32'(dout_rf),  32'h0000AA);
    acc(1'b1, 1'b0, 3'b000, 4'd0, 24'h0);
    chk("nc_rd_new", 32'(dout_nc), 32'hFFFFFF);

    // Output-register pipeline
    acc(1'b1, 1'b1, 3'b111, 4'd1, 24'h000001);
    acc(1'b1, 1'b1, 3'b111, 4'd2, 24'h000002);
    acc(1'b1, 1'b1, 3'b111, 4'd3, 24'h000003);
    acc(1'b0, 1'b0, 3'b000, 4'd0, 24'h0);
    acc(1'b1, 1'b0, 3'b000, 4'd1, 24'h0);
    chk("or_e1_vld", 32'(valid_or), 32'd0);
    acc(1'b1, 1'b0, 3'b000, 4'd2, 24'h0);
    chk("or_e2",     32'(dout_or),  32'h000001);
    chk("or_e2_vld", 32'(valid_or), 32'd1);
    chk("wf_e2",     32'(dout_wf),  32'h000002);
    acc(1'b1, 1'b0, 3'b000, 4'd3, 24'h0);
    chk("or_e3",     32'(dout_or),  32'h000002);
    acc(1'b0, 1'b0, 3'b000, 4'd0, 24'h0);
    chk("or_e4",     32'(dout_or),  32'h000003);
    chk("or_e4_vld", 32'(valid_or), 32'd1);
    tick();
    chk("or_hold",     32'(dout_or),  32'h000003);
    chk("or_hold_vld", 32'(valid_or), 32'd0);

    // Reset in the middle of a clear
    acc(1'b1, 1'b1, 3'b111, 4'd5, 24'h123456);
    en = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (7) tick();
    chk("mid_busy", 32'(busy_wf), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_dout", 32'(dout_wf), 32'h0);
    rst_n = 1'b1;
    en = 1'b1; we = 1'b1; be = 3'b111; addr = 4'd5; din = 24'hFFFFFF;
    wait_idle(n_busy);
    chk("restart_cycles", 32'(n_busy), 32'd16);
    chk("restart_no_valid", 32'(n_bad_valid), 32'd0);
    acc(1'b1, 1'b0, 3'b000, 4'd5, 24'h0);
    chk("busy_wr_ignored", 32'(dout_wf),  32'h0);
    chk("post_clear_vld",  32'(valid_wf), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
